// File: rtl/iob_gpio_sensor_filter_pkg.sv
// iob_gpio_sensor_filter_pkg: shared debounce FSM states and helpers.
// Imported by the channel slice and the top.
package iob_gpio_sensor_filter_pkg;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HI      = 2'd2,
    S_WAIT_LO = 2'd3
  } state_e;

  // LSB of channel ch inside the packed event_cnt bus
  function automatic int unsigned cnt_lsb(
    input int unsigned ch,
    input int unsigned w
  );
    return ch * w;
  endfunction

endpackage

// File: rtl/iob_gpio_sensor_filter_ch.sv
// iob_gpio_sensor_filter_ch: one sensor channel.
// 2-FF sync, debounce FSM, edge pulses, saturating rise counter.
module iob_gpio_sensor_filter_ch
  import iob_gpio_sensor_filter_pkg::*;
#(
  parameter int DEBOUNCE_W   = 20,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             sensor_raw,
  input  logic             enable,
  input  logic             clear,
  output logic             sensor_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic             overflow
);

  localparam logic [DEBOUNCE_W-1:0] LAST =
    DEBOUNCE_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE =
    CNT_MAX - CNT_W'(1);

  logic                  sync1;
  logic                  sync2;
  state_e                state;
  logic [DEBOUNCE_W-1:0] cnt;
  logic                  done;
  logic                  rise_set;

  // Two back-to-back flops, nothing in between
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
    end
  end

  // >= lets DEBOUNCE_CYC=1 leave the wait state on its first cycle
  assign done     = (cnt >= LAST);
  assign rise_set = enable && (state == S_WAIT_HI)
                    && sync2 && done;

  // Debounce FSM with registered level and edge pulses
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_LO;
      cnt        <= '0;
      sensor_out <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (enable) begin
        unique case (state)
          S_LO: begin
            if (sync2) begin
              state <= S_WAIT_HI;
              cnt   <= DEBOUNCE_W'(1);
            end
          end
          S_WAIT_HI: begin
            if (!sync2) begin
              state <= S_LO;
              cnt   <= '0;
            end else if (done) begin
              state      <= S_HI;
              cnt        <= '0;
              sensor_out <= 1'b1;
              rise_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_HI: begin
            if (!sync2) begin
              state <= S_WAIT_LO;
              cnt   <= DEBOUNCE_W'(1);
            end
          end
          S_WAIT_LO: begin
            if (sync2) begin
              state <= S_HI;
              cnt   <= '0;
            end else if (done) begin
              state      <= S_LO;
              cnt        <= '0;
              sensor_out <= 1'b0;
              fall_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_LO;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Rise counter moves with the accepted edge; clear wins
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else if (rise_set) begin
      if (event_cnt != CNT_MAX) begin
        event_cnt <= event_cnt + 1'b1;
      end
      if (event_cnt >= CNT_PRE) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_gpio_sensor_filter.sv
// iob_gpio_sensor_filter: N_CH debounced sensor channels for iob_gpio.
// Define IOB_GPIO_SENSOR_FILTER_IRQ_EN for the sticky irq/irq_ack pair.
module iob_gpio_sensor_filter
  import iob_gpio_sensor_filter_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int DEBOUNCE_W   = 20,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [N_CH-1:0]       sensor_raw,
  input  logic                  enable,
  input  logic                  clear,
  output logic [N_CH-1:0]       sensor_out,
  output logic [N_CH-1:0]       rise_pulse,
  output logic [N_CH-1:0]       fall_pulse,
  output logic [N_CH*CNT_W-1:0] event_cnt,
  output logic [N_CH-1:0]       overflow
`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_ack
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    iob_gpio_sensor_filter_ch #(
      .DEBOUNCE_W  (DEBOUNCE_W),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .arst_n    (arst_n),
      .sensor_raw(sensor_raw[i]),
      .enable    (enable),
      .clear     (clear),
      .sensor_out(sensor_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .event_cnt (event_cnt[cnt_lsb(i, CNT_W) +: CNT_W]),
      .overflow  (overflow[i])
    );
  end

`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
  // Sticky irq; a fresh pulse beats a same-cycle ack
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      irq <= 1'b0;
    end else if ((|rise_pulse) || (|fall_pulse)) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_iob_gpio_sensor_filter.sv
// tb_iob_gpio_sensor_filter: directed + random bench against a
// run-length reference model of the debounce filter.
module tb_iob_gpio_sensor_filter;

  localparam int N_CH = 2;
  localparam int DW   = 20;
  localparam int DEB  = 4;
  localparam int CW   = 4;

  logic             clk;
  logic             arst_n;
  logic [N_CH-1:0]  raw;
  logic             en;
  logic             clr;
  logic [N_CH-1:0]  sensor_out;
  logic [N_CH-1:0]  rise_pulse;
  logic [N_CH-1:0]  fall_pulse;
  logic [N_CH*CW-1:0] event_cnt;
  logic [N_CH-1:0]  overflow;
`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
  logic             irq;
  logic             ack;
`endif

  int tests;
  int fails;

  iob_gpio_sensor_filter #(
    .N_CH        (N_CH),
    .DEBOUNCE_W  (DW),
    .DEBOUNCE_CYC(DEB),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .sensor_raw(raw),
    .enable    (en),
    .clear     (clr),
    .sensor_out(sensor_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .event_cnt (event_cnt),
    .overflow  (overflow)
`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
    ,
    .irq       (irq),
    .irq_ack   (ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw seen by the filter two edges later; the
  // level flips once DEB consecutive enabled samples differ from it.
  logic [N_CH-1:0] m_d1;
  logic [N_CH-1:0] m_d2;
  logic [N_CH-1:0] m_out;
  logic [N_CH-1:0] m_rise;
  logic [N_CH-1:0] m_fall;
  logic [N_CH-1:0] m_ov;
  logic [CW-1:0]   m_cnt [N_CH];
  int              m_run [N_CH];
  logic            m_irq;

  function automatic logic [N_CH*CW-1:0] m_cnt_bus();
    logic [N_CH*CW-1:0] b;
    for (int c = 0; c < N_CH; c++) b[c*CW +: CW] = m_cnt[c];
    return b;
  endfunction

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_out = '0;
    m_rise = '0; m_fall = '0; m_ov = '0; m_irq = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c] = '0;
      m_run[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] seen;
    logic [N_CH-1:0] nr;
    logic [N_CH-1:0] nf;
    logic            prev;
    prev = (|m_rise) || (|m_fall);
    seen = m_d2;
    m_d2 = m_d1;
    m_d1 = raw;
    nr = '0;
    nf = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (en) begin
        if (seen[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_out[c] = seen[c];
            m_run[c] = 0;
            if (seen[c]) nr[c] = 1'b1;
            else         nf[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      if (clr) begin
        m_cnt[c] = '0;
        m_ov[c]  = 1'b0;
      end else if (nr[c]) begin
        if (m_cnt[c] != {CW{1'b1}}) m_cnt[c] = m_cnt[c] + 1'b1;
        if (m_cnt[c] == {CW{1'b1}}) m_ov[c] = 1'b1;
      end
    end
    m_rise = nr;
    m_fall = nf;
`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
    if (prev)     m_irq = 1'b1;
    else if (ack) m_irq = 1'b0;
`else
    m_irq = prev;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0; raw = '0; en = 1'b1; clr = 1'b0;
`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
    ack = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({sensor_out, rise_pulse, fall_pulse, overflow} !== '0
        || event_cnt !== '0) begin
      fails++;
      $display("FAIL reset_outs got out=%b cnt=%h exp 0",
               sensor_out, event_cnt);
    end
    arst_n = 1'b1;
    tick();
    tests++;
    if (sensor_out !== 2'b00 || event_cnt !== '0) begin
      fails++;
      $display("FAIL reset_release got out=%b cnt=%h exp 0",
               sensor_out, event_cnt);
    end
  endtask

  task automatic test_clean_step();
    raw[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (sensor_out[0] !== 1'b0) begin
      fails++;
      $display("FAIL step_early got %b exp 0", sensor_out[0]);
    end
    tick();
    tests++;
    if (sensor_out[0] !== 1'b1 || rise_pulse[0] !== 1'b1
        || event_cnt[CW-1:0] !== 4'd1) begin
      fails++;
      $display("FAIL step_6clk got out=%b rise=%b cnt=%0d exp 1 1 1",
               sensor_out[0], rise_pulse[0], event_cnt[CW-1:0]);
    end
    tick();
    tests++;
    if (rise_pulse[0] !== 1'b0 || sensor_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL step_pulse_len got rise=%b out=%b exp 0 1",
               rise_pulse[0], sensor_out[0]);
    end
  endtask

  task automatic test_glitch();
    raw[1] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    raw[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (sensor_out[1] !== 1'b0 || rise_pulse !== '0
          || fall_pulse !== '0 || event_cnt !== 8'h01) begin
        fails++;
        $display("FAIL glitch cyc %0d got out=%b r=%b f=%b cnt=%h",
                 i, sensor_out, rise_pulse, fall_pulse, event_cnt);
      end
    end
  endtask

  task automatic test_overflow_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++;
    if (event_cnt[CW-1:0] !== 4'd0) begin
      fails++;
      $display("FAIL pre_clear got %0d exp 0", event_cnt[CW-1:0]);
    end
    for (int e = 0; e < 17; e++) begin
      raw[0] = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      raw[0] = 1'b1;
      for (int i = 0; i < 7; i++) tick();
    end
    tests++;
    if (event_cnt[CW-1:0] !== 4'd15 || overflow[0] !== 1'b1
        || event_cnt !== m_cnt_bus() || overflow !== m_ov) begin
      fails++;
      $display("FAIL ovf got cnt=%0d ov=%b exp 15 1",
               event_cnt[CW-1:0], overflow[0]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++;
    if (event_cnt[CW-1:0] !== 4'd0 || overflow[0] !== 1'b0) begin
      fails++;
      $display("FAIL clear got cnt=%0d ov=%b exp 0 0",
               event_cnt[CW-1:0], overflow[0]);
    end
    raw[0] = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    raw[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++;
    if (rise_pulse[0] !== 1'b1 || event_cnt[CW-1:0] !== 4'd0) begin
      fails++;
      $display("FAIL clear_vs_rise got rise=%b cnt=%0d exp 1 0",
               rise_pulse[0], event_cnt[CW-1:0]);
    end
  endtask

  task automatic test_enable();
    raw[1] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (sensor_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0
          || event_cnt[CW +: CW] !== 4'd0) begin
        fails++;
        $display("FAIL en_hold cyc %0d got out=%b rise=%b",
                 i, sensor_out[1], rise_pulse[1]);
      end
    end
    en = 1'b1;
    tick();
    tick();
    tests++;
    if (sensor_out[1] !== 1'b0) begin
      fails++;
      $display("FAIL en_resume_early got %b exp 0", sensor_out[1]);
    end
    tick();
    tests++;
    if (sensor_out[1] !== 1'b1 || rise_pulse[1] !== 1'b1
        || event_cnt[CW +: CW] !== 4'd1) begin
      fails++;
      $display("FAIL en_resume got out=%b rise=%b cnt=%0d exp 1 1 1",
               sensor_out[1], rise_pulse[1], event_cnt[CW +: CW]);
    end
  endtask

  task automatic test_async_reset();
    raw = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    raw[0] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if ({sensor_out, rise_pulse, fall_pulse, overflow} !== '0
        || event_cnt !== '0) begin
      fails++;
      $display("FAIL arst_wait got out=%b cnt=%h exp 0",
               sensor_out, event_cnt);
    end
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (sensor_out[0] !== 1'b0) begin
      fails++;
      $display("FAIL arst_recov_early got %b exp 0", sensor_out[0]);
    end
    tick();
    tests++;
    if (sensor_out[0] !== 1'b1 || event_cnt[CW-1:0] !== 4'd1) begin
      fails++;
      $display("FAIL arst_recov got out=%b cnt=%0d exp 1 1",
               sensor_out[0], event_cnt[CW-1:0]);
    end
    tick();
    tick();
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (sensor_out !== '0 || event_cnt !== '0) begin
      fails++;
      $display("FAIL arst_hi got out=%b cnt=%h exp 0",
               sensor_out, event_cnt);
    end
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0) raw = N_CH'($urandom);
      en  = ($urandom_range(9) != 0);
      clr = ($urandom_range(79) == 0);
`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
      ack = ($urandom_range(3) == 0);
`endif
      tick();
      tests++;
      if (sensor_out !== m_out || rise_pulse !== m_rise
          || fall_pulse !== m_fall) begin
        fails++;
        $display("FAIL rnd_lvl cyc %0d got %b/%b/%b exp %b/%b/%b",
                 c, sensor_out, rise_pulse, fall_pulse,
                 m_out, m_rise, m_fall);
      end
      tests++;
      if (event_cnt !== m_cnt_bus() || overflow !== m_ov) begin
        fails++;
        $display("FAIL rnd_cnt cyc %0d got %h/%b exp %h/%b",
                 c, event_cnt, overflow, m_cnt_bus(), m_ov);
      end
`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
      tests++;
      if (irq !== m_irq) begin
        fails++;
        $display("FAIL rnd_irq cyc %0d got %b exp %b", c, irq, m_irq);
      end
`endif
    end
    en = 1'b1; clr = 1'b0;
  endtask

`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
  task automatic test_irq();
    int n;
    ack = 1'b0;
    raw = 2'b10;
    for (int i = 0; i < 10; i++) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    raw[1] = 1'b0;
    n = 0;
    while (fall_pulse[1] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (fall_pulse[1] !== 1'b1) begin
      fails++;
      $display("FAIL irq_fall_timeout got %b exp 1", fall_pulse[1]);
    end
    tick();
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_set got %b exp 1", irq);
    end
    raw[0] = 1'b1;
    n = 0;
    while (rise_pulse[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    ack = 1'b1;
    tick();
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_ack_vs_pulse got %b exp 1", irq);
    end
    tick();
    ack = 1'b0;
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_ack got %b exp 0", irq);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_overflow_clear();
    test_enable();
    test_async_reset();
    test_random();
`ifdef IOB_GPIO_SENSOR_FILTER_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
